// File: rtl/fft_input_loader.sv
// rtl/fft_input_loader.sv - ping-pong sample buffer feeding an in-place radix-2 DIT FFT
// Samples land at bit-reversed addresses so a linear read yields FFT input order.
module fft_input_loader #(
    parameter int N_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       sample_in,
    input  logic              sample_valid,
    input  logic [N_LOG2-1:0] rd_addr,
    output logic [12:0]       rd_data_re,
    output logic [12:0]       rd_data_im,
    output logic              frame_ready,
    input  logic              frame_release,
    output logic              overrun,
    output logic [7:0]        drop_count
);

    localparam int N = 1 << N_LOG2;

    logic [11:0] bank0 [N];
    logic [11:0] bank1 [N];

    logic              wb_q, wb_d;
    logic              rb_q, rb_d;
    logic [1:0]        full_q, full_d;
    logic [N_LOG2-1:0] wcnt_q, wcnt_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        drop_count_q, drop_count_d;
    logic [12:0]       rd_data_q, rd_data_d;

    logic              accept;
    logic              drop;
    logic              release_ok;
    logic [N_LOG2-1:0] wr_addr;

    always_comb begin
        wr_addr = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            wr_addr[i] = wcnt_q[N_LOG2-1-i];
        end
    end

    // Full flags are judged on registered state only, so a release never frees a bank for a same-cycle sample.
    assign accept     = sample_valid && !full_q[wb_q];
    assign drop       = sample_valid && full_q[wb_q];
    assign release_ok = frame_release && full_q[rb_q];

    always_comb begin
        wb_d         = wb_q;
        rb_d         = rb_q;
        full_d       = full_q;
        wcnt_d       = wcnt_q;
        overrun_d    = drop;
        drop_count_d = drop_count_q;
        rd_data_d    = {1'b0, rb_q ? bank1[rd_addr] : bank0[rd_addr]};

        if (accept) begin
            wcnt_d = wcnt_q + N_LOG2'(1);
            if (&wcnt_q) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end
        end

        // A completing write and a release always target different banks, so both apply.
        if (release_ok) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
        end

        if (drop && drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q         <= 1'b0;
            rb_q         <= 1'b0;
            full_q       <= 2'b00;
            wcnt_q       <= '0;
            overrun_q    <= 1'b0;
            drop_count_q <= 8'd0;
            rd_data_q    <= 13'd0;
        end else begin
            wb_q         <= wb_d;
            rb_q         <= rb_d;
            full_q       <= full_d;
            wcnt_q       <= wcnt_d;
            overrun_q    <= overrun_d;
            drop_count_q <= drop_count_d;
            rd_data_q    <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            if (wb_q) begin
                bank1[wr_addr] <= sample_in;
            end else begin
                bank0[wr_addr] <= sample_in;
            end
        end
    end

    assign rd_data_re  = rd_data_q;
    assign rd_data_im  = 13'd0;
    assign frame_ready = full_q[rb_q];
    assign overrun     = overrun_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// tb/tb_fft_input_loader.sv - directed table-driven bench for fft_input_loader (N_LOG2=3)
module tb_fft_input_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic [2:0]  rd_addr;
    logic [12:0] rd_data_re;
    logic [12:0] rd_data_im;
    logic        frame_ready;
    logic        frame_release;
    logic        overrun;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;

    fft_input_loader #(.N_LOG2(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .rd_addr       (rd_addr),
        .rd_data_re    (rd_data_re),
        .rd_data_im    (rd_data_im),
        .frame_ready   (frame_ready),
        .frame_release (frame_release),
        .overrun       (overrun),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [11:0] din;
        logic        rel;
        logic [2:0]  addr;
        logic        e_fr;
        logic        e_ov;
        logic [7:0]  e_dc;
        logic        chk_rd;
        logic [12:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic sv, input logic [11:0] din, input logic rel, input logic [2:0] addr,
                       input logic e_fr, input logic e_ov, input logic [7:0] e_dc,
                       input logic chk_rd, input logic [12:0] e_rd);
        vec_t v;
        v.sv = sv; v.din = din; v.rel = rel; v.addr = addr;
        v.e_fr = e_fr; v.e_ov = e_ov; v.e_dc = e_dc; v.chk_rd = chk_rd; v.e_rd = e_rd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic sv, input logic [11:0] din, input logic rel, input logic [2:0] addr);
        rst           = r;
        sample_valid  = sv;
        sample_in     = din;
        frame_release = rel;
        rd_addr       = addr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [12:0] bitrev_exp [8];
        bitrev_exp = '{13'd0, 13'd4, 13'd2, 13'd6, 13'd1, 13'd5, 13'd3, 13'd7};

        // continuous first frame
        for (int i = 0; i < 8; i++) add(1'b1, 12'(i), 1'b0, 3'd0, i == 7, 1'b0, 8'd0, 1'b0, 13'd0);
        for (int a = 0; a < 8; a++) add(1'b0, 12'd0, 1'b0, 3'(a), 1'b1, 1'b0, 8'd0, 1'b1, bitrev_exp[a]);
        // second bank fills, then drops
        for (int i = 8; i < 16; i++) add(1'b1, 12'(i), 1'b0, 3'd0, 1'b1, 1'b0, 8'd0, 1'b0, 13'd0);
        add(1'b1, 12'd99, 1'b0, 3'd0, 1'b1, 1'b1, 8'd1, 1'b0, 13'd0);
        add(1'b0, 12'd0,  1'b0, 3'd0, 1'b1, 1'b0, 8'd1, 1'b0, 13'd0);
        // sample together with the release that frees the write bank is still dropped
        add(1'b1, 12'd77, 1'b1, 3'd0, 1'b1, 1'b1, 8'd2, 1'b0, 13'd0);
        add(1'b0, 12'd0,  1'b0, 3'd0, 1'b1, 1'b0, 8'd2, 1'b1, 13'd8);
        add(1'b0, 12'd0,  1'b0, 3'd4, 1'b1, 1'b0, 8'd2, 1'b1, 13'd9);
        for (int i = 20; i < 27; i++) add(1'b1, 12'(i), 1'b0, 3'd0, 1'b1, 1'b0, 8'd2, 1'b0, 13'd0);
        // completion of bank 0 and release of bank 1 in one cycle
        add(1'b1, 12'd27, 1'b1, 3'd0, 1'b1, 1'b0, 8'd2, 1'b0, 13'd0);
        add(1'b0, 12'd0,  1'b0, 3'd0, 1'b1, 1'b0, 8'd2, 1'b1, 13'd20);
        add(1'b0, 12'd0,  1'b0, 3'd4, 1'b1, 1'b0, 8'd2, 1'b1, 13'd21);
        add(1'b0, 12'd0,  1'b0, 3'd7, 1'b1, 1'b0, 8'd2, 1'b1, 13'd27);
        add(1'b0, 12'd0,  1'b1, 3'd0, 1'b0, 1'b0, 8'd2, 1'b1, 13'd20);
        // release with nothing ready must not move rb
        add(1'b0, 12'd0,  1'b1, 3'd0, 1'b0, 1'b0, 8'd2, 1'b1, 13'd8);
        add(1'b0, 12'd0,  1'b0, 3'd0, 1'b0, 1'b0, 8'd2, 1'b1, 13'd8);

        step(1'b1, 1'b0, 12'd0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 12'd0, 1'b0, 3'd0);
        step(1'b0, 1'b0, 12'd0, 1'b0, 3'd0);
        check("reset_frame_ready", frame_ready, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_drop_count", drop_count, 8'd0);
        check("reset_rd_data_re", rd_data_re, 13'd0);
        check("reset_rd_data_im", rd_data_im, 13'd0);

        foreach (vecs[k]) begin
            step(1'b0, vecs[k].sv, vecs[k].din, vecs[k].rel, vecs[k].addr);
            check($sformatf("vec%0d_frame_ready", k), frame_ready, vecs[k].e_fr);
            check($sformatf("vec%0d_overrun", k), overrun, vecs[k].e_ov);
            check($sformatf("vec%0d_drop_count", k), drop_count, vecs[k].e_dc);
            if (vecs[k].chk_rd) check($sformatf("vec%0d_rd_data_re", k), rd_data_re, vecs[k].e_rd);
        end

        // fill both banks, then saturate the drop counter
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 12'(100 + i), 1'b0, 3'd0);
        check("both_full_frame_ready", frame_ready, 1'b1);
        check("both_full_no_overrun", overrun, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 12'd5, 1'b0, 3'd0);
            if (i == 0) begin
                check("first_drop_overrun", overrun, 1'b1);
                check("first_drop_count", drop_count, 8'd3);
            end
        end
        check("sat_drop_count", drop_count, 8'd255);
        check("sat_overrun", overrun, 1'b1);
        step(1'b0, 1'b0, 12'd0, 1'b0, 3'd0);
        check("sat_idle_overrun", overrun, 1'b0);
        check("sat_idle_drop_count", drop_count, 8'd255);

        // mid-frame reset wins over valid and release
        step(1'b0, 1'b0, 12'd0, 1'b1, 3'd0);
        check("release_one_frame_ready", frame_ready, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 12'(50 + i), 1'b0, 3'd0);
        check("partial_no_overrun", overrun, 1'b0);
        step(1'b1, 1'b1, 12'd1, 1'b1, 3'd0);
        check("midrst_frame_ready", frame_ready, 1'b0);
        check("midrst_drop_count", drop_count, 8'd0);
        check("midrst_overrun", overrun, 1'b0);
        check("midrst_rd_data_re", rd_data_re, 13'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 12'(10 + i), 1'b0, 3'd0);
            check($sformatf("postrst_s%0d_frame_ready", i), frame_ready, i == 7);
        end
        step(1'b0, 1'b0, 12'd0, 1'b0, 3'd1);
        check("postrst_addr1", rd_data_re, 13'd14);
        check("postrst_drop_count", drop_count, 8'd0);

        // full-scale sample at time index 1 lands at address 4
        step(1'b1, 1'b0, 12'd0, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, (i == 1) ? 12'd4095 : 12'd0, 1'b0, 3'd0);
        check("max_frame_ready", frame_ready, 1'b1);
        step(1'b0, 1'b0, 12'd0, 1'b0, 3'd4);
        check("max_rd_data_re", rd_data_re, 13'h0FFF);
        check("max_rd_data_im", rd_data_im, 13'd0);
        step(1'b0, 1'b0, 12'd0, 1'b0, 3'd1);
        check("max_addr1_zero", rd_data_re, 13'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
